// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_share_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one combinational 16-bit
//             ALU among N_REQ requesters. Winning request is latched, driven
//             to the ALU for one cycle, and the captured result and masked
//             flags are returned on one tagged response channel with
//             backpressure. Flow per operation: IDLE (grant) -> EXEC -> RESP.
//  Options  : define ALU_SHARE_ARBITER_STATS_EN to add the stat_clr,
//             stat_ops and stat_wait counters.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [3*N_REQ-1:0]    req_op,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  output logic [2:0]            alu_op,
  output logic [15:0]           alu_a,
  output logic [15:0]           alu_b,
  input  logic [15:0]           alu_out,
  input  logic                  alu_sign,
  input  logic                  alu_zero,
  input  logic                  alu_parity,
  input  logic                  alu_overflow,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_data,
  output logic [3:0]            rsp_flags,
  output logic                  busy
`ifdef ALU_SHARE_ARBITER_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [31:0]           stat_ops,
  output logic [31:0]           stat_wait
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_ptr;

  logic            w_any;
  logic [ID_W-1:0] w_win;
  logic [ID_W-1:0] w_scan;
  logic            w_grant;
  logic [2:0]      w_op;
  logic [15:0]     w_a;
  logic [15:0]     w_b;
  logic            w_sign_cap;
  logic            w_ovf_cap;

  // Modular add on requester indices; base is always below N_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[ID_W-1:0];
  endfunction

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    w_any  = 1'b0;
    w_win  = r_ptr;
    w_scan = r_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      w_scan = wrap_add(r_ptr, k);
      if (!w_any && req_valid[w_scan]) begin
        w_any = 1'b1;
        w_win = w_scan;
      end
    end
  end

  // Grants only happen in IDLE; the handshake completes in the same cycle.
  assign w_grant = (r_state == IDLE) && w_any;

  // Payload of the winning requester.
  always_comb begin
    w_op = req_op[3*int'(w_win) +: 3];
    w_a  = req_a[16*int'(w_win) +: 16];
    w_b  = req_b[16*int'(w_win) +: 16];
  end

  // One-hot ready to the winner only.
  always_comb begin
    req_ready = '0;
    if (w_grant) req_ready[w_win] = 1'b1;
  end

  // Sign is meaningful only for the arithmetic ops, overflow only for ADD;
  // forcing them to 0 otherwise also keeps an undriven ALU flag out of rsp_flags.
  assign w_sign_cap = (alu_op[2:1] == 2'b00) ? alu_sign     : 1'b0;
  assign w_ovf_cap  = (alu_op == 3'b000)     ? alu_overflow : 1'b0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    rsp_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_grant) w_state_nxt = EXEC;
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Latch the granted request and pointer; capture ALU result at end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      rsp_id    <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
    end else begin
      if (w_grant) begin
        alu_op <= w_op;
        alu_a  <= w_a;
        alu_b  <= w_b;
        rsp_id <= w_win;
        r_ptr  <= wrap_add(w_win, 1);
      end
      if (r_state == EXEC) begin
        rsp_data  <= alu_out;
        rsp_flags <= {w_ovf_cap, alu_parity, alu_zero, w_sign_cap};
      end
    end
  end

`ifdef ALU_SHARE_ARBITER_STATS_EN
  logic w_ops_evt;
  logic w_wait_evt;

  assign w_ops_evt  = rsp_valid && rsp_ready;
  // A valid request with no grant in IDLE cannot happen; it stays as a check.
  assign w_wait_evt = ((r_state == IDLE) && (|req_valid) && !w_any) ||
                      ((r_state == RESP) && (|req_valid));

  // Saturating event counters; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops  <= '0;
      stat_wait <= '0;
    end else if (stat_clr) begin
      stat_ops  <= '0;
      stat_wait <= '0;
    end else begin
      if (w_ops_evt  && (stat_ops  != 32'hFFFF_FFFF)) stat_ops  <= stat_ops + 32'd1;
      if (w_wait_evt && (stat_wait != 32'hFFFF_FFFF)) stat_wait <= stat_wait + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_share_arbiter
//  Purpose  : Directed bench for alu_share_arbiter with a scoreboard of
//             expected responses pushed at grant and checked at response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [3*N_REQ-1:0]  req_op;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic [2:0]          alu_op;
  logic [15:0]         alu_a;
  logic [15:0]         alu_b;
  logic [15:0]         alu_out;
  logic                alu_sign, alu_zero, alu_parity, alu_overflow;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [15:0]         rsp_data;
  logic [3:0]          rsp_flags;
  logic                busy;
`ifdef ALU_SHARE_ARBITER_STATS_EN
  logic                stat_clr;
  logic [31:0]         stat_ops;
  logic [31:0]         stat_wait;
`endif

  always #5 clk = ~clk;

  alu_share_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_sign(alu_sign), .alu_zero(alu_zero),
    .alu_parity(alu_parity), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .busy(busy)
`ifdef ALU_SHARE_ARBITER_STATS_EN
    , .stat_clr(stat_clr), .stat_ops(stat_ops), .stat_wait(stat_wait)
`endif
  );

  // Shared ALU: sign/overflow undriven (X) for ops where they mean nothing.
  always_comb begin
    alu_sign     = 1'bx;
    alu_overflow = 1'bx;
    case (alu_op)
      3'd0:    alu_out = alu_a + alu_b;
      3'd1:    alu_out = alu_a - alu_b;
      3'd2:    alu_out = alu_a & alu_b;
      3'd3:    alu_out = alu_a | alu_b;
      3'd4:    alu_out = alu_a ^ alu_b;
      default: alu_out = alu_a;
    endcase
    if (alu_op[2:1] == 2'b00) alu_sign = alu_out[15];
    if (alu_op == 3'd0) alu_overflow = (alu_a[15] == alu_b[15]) && (alu_out[15] != alu_a[15]);
    alu_zero   = (alu_out == 16'h0);
    alu_parity = ~^alu_out;
  end

  typedef struct {
    logic [ID_W-1:0] id;
    logic [15:0]     data;
    logic [3:0]      flags;
    int              gcyc;
  } exp_t;

  exp_t            sb[$];
  int              grant_log[$];
  int              grant_cyc[$];
  int              total = 0;
  int              bad   = 0;
  int              cyc   = 0;
  int              n_rsp = 0;
  logic [N_REQ-1:0] hold = '0;
  logic [N_REQ-1:0] granted;
  logic            prev_rv = 1'b0;
  logic [ID_W-1:0] last_id;
  logic [15:0]     last_data;
  logic [3:0]      last_flags;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result: {ovf, parity, zero, sign, data} with flag masking applied.
  function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] d;
    logic        s, o;
    case (op)
      3'd0:    d = a + b;
      3'd1:    d = a - b;
      3'd2:    d = a & b;
      3'd3:    d = a | b;
      3'd4:    d = a ^ b;
      default: d = a;
    endcase
    s = (op[2:1] == 2'b00) ? d[15] : 1'b0;
    o = (op == 3'd0) ? ((a[15] == b[15]) && (d[15] != a[15])) : 1'b0;
    return {o, ~^d, (d == 16'h0), s, d};
  endfunction

  task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    req_op[3*i +: 3]  = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_valid[i]      = 1'b1;
  endtask

  // One clock: observe at negedge, then drive requester updates after posedge.
  task automatic cycle();
    exp_t        e;
    logic [19:0] m;
    int          g;
    @(negedge clk);
    granted = req_ready;
    chk("ready_onehot", ($countones(req_ready) <= 1) ? 32'd1 : 32'd0, 32'd1);
    if (req_ready != '0) begin
      chk("ready_while_busy", {31'd0, busy}, 32'd0);
      g = 0;
      for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
      chk("ready_without_valid", {31'd0, req_valid[g]}, 32'd1);
      m = model(req_op[3*g +: 3], req_a[16*g +: 16], req_b[16*g +: 16]);
      e.id    = ID_W'(g);
      e.data  = m[15:0];
      e.flags = m[19:16];
      e.gcyc  = cyc;
      sb.push_back(e);
      grant_log.push_back(g);
      grant_cyc.push_back(cyc);
    end
    if (rsp_valid && !prev_rv) begin
      chk("pending_at_rsp", sb.size(), 32'd1);
      if (sb.size() != 0) chk("latency", cyc, sb[0].gcyc + 2);
    end
    if (rsp_valid && rsp_ready && sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
      chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
      chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, e.flags});
      last_id    = rsp_id;
      last_data  = rsp_data;
      last_flags = rsp_flags;
      n_rsp++;
    end
    prev_rv = rsp_valid && !rsp_ready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N_REQ; i++) if (granted[i] && !hold[i]) req_valid[i] = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((sb.size() != 0 || req_valid != '0 || busy) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_in_budget", (n < maxc) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    sb.delete();
    prev_rv = 1'b0;
    rst_n   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base_rsp;
    logic [ID_W-1:0] h_id;
    logic [15:0]     h_data;
    logic [3:0]      h_flags;

    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
`ifdef ALU_SHARE_ARBITER_STATS_EN
    stat_clr  = 1'b0;
`endif
    cycle();
    cycle();
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    cycle();

    // Single requester, signed overflow on ADD.
    set_req(0, 3'd0, 16'h7FFF, 16'h0001);
    drain(20);
    chk("t1_id", {30'd0, last_id}, 32'd0);
    chk("t1_data", {16'd0, last_data}, 32'h8000);
    chk("t1_flags", {28'd0, last_flags}, 32'b1001);

    // XOR: sign/overflow masked even though the ALU leaves them X.
    set_req(1, 3'd4, 16'h00FF, 16'h00FF);
    drain(20);
    chk("t2_id", {30'd0, last_id}, 32'd1);
    chk("t2_data", {16'd0, last_data}, 32'h0000);
    chk("t2_flags", {28'd0, last_flags}, 32'b0110);

    // Round robin with all requesters continuously valid.
    do_reset();
    grant_log.delete();
    grant_cyc.delete();
    hold = '1;
    for (int i = 0; i < N_REQ; i++) set_req(i, 3'd0, 16'(16'h1111 * (i + 1)), 16'(i));
    repeat (18) cycle();
    hold = '0;
    drain(40);
    chk("rr_grant_count", (grant_log.size() >= 6) ? 32'd1 : 32'd0, 32'd1);
    if (grant_log.size() >= 6) begin
      for (int k = 0; k < 6; k++) chk("rr_order", grant_log[k], k % N_REQ);
      for (int k = 0; k < 5; k++) chk("rr_spacing", grant_cyc[k+1] - grant_cyc[k], 32'd3);
    end

    // Backpressure: response held for 5 cycles while another request waits.
    rsp_ready = 1'b0;
    set_req(2, 3'd1, 16'h0005, 16'h0007);
    n = 0;
    while (!rsp_valid && n < 10) begin
      cycle();
      n++;
    end
    chk("bp_reach_resp", {31'd0, rsp_valid}, 32'd1);
    chk("bp_data", {16'd0, rsp_data}, 32'hFFFE);
    chk("bp_flags", {28'd0, rsp_flags}, 32'b0001);
    set_req(3, 3'd3, 16'hA000, 16'h0005);
    h_id    = rsp_id;
    h_data  = rsp_data;
    h_flags = rsp_flags;
    repeat (5) begin
      cycle();
      chk("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
      chk("bp_id_stable", {30'd0, rsp_id}, {30'd0, h_id});
      chk("bp_data_stable", {16'd0, rsp_data}, {16'd0, h_data});
      chk("bp_flags_stable", {28'd0, rsp_flags}, {28'd0, h_flags});
      chk("bp_no_ready", {28'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_release_idle", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_grant", {28'd0, req_ready}, 32'b1000);
    drain(20);

    // Reset while an operation is in EXEC.
    set_req(1, 3'd0, 16'h0001, 16'h0002);
    n = 0;
    while (granted == '0 && n < 10) begin
      cycle();
      n++;
    end
    chk("mid_busy_exec", {31'd0, busy}, 32'd1);
    chk("mid_alu_a", {16'd0, alu_a}, 32'h0001);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("mid_rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    sb.delete();
    req_valid = '0;
    cycle();
    cycle();
    prev_rv = 1'b0;
    rst_n   = 1'b1;
    base_rsp = n_rsp;
    grant_log.delete();
    set_req(2, 3'd2, 16'hF0F0, 16'h0FF0);
    set_req(1, 3'd0, 16'h8000, 16'h8000);
    set_req(0, 3'd1, 16'h0000, 16'h0000);
    drain(40);
    chk("mid_first_winner", (grant_log.size() > 0) ? grant_log[0] : -1, 32'd0);
    chk("mid_rsp_count", n_rsp - base_rsp, 32'd3);

`ifdef ALU_SHARE_ARBITER_STATS_EN
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    chk("stat_ops_clr0", stat_ops, 32'd0);
    for (int i = 0; i < 3; i++) set_req(i, 3'd0, 16'(i), 16'h0001);
    drain(40);
    chk("stat_ops_three", stat_ops, 32'd3);
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    chk("stat_ops_clr1", stat_ops, 32'd0);
    chk("stat_wait_clr", stat_wait, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational 16-bit ALU with flags among N_REQ requesters. Each requester issues {op, a, b} over a valid/ready handshake. The block latches the winning request, drives the shared ALU, and captures the result and flags. It then returns them on a single tagged response channel with backpressure. It sits between the compute clients and the single ALU instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
ID_W, 2, response tag width, equal to clog2(N_REQ)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle
req_op  in  3*N_REQ  packed ALU op, requester i at [3i+2:3i]
req_a  in  16*N_REQ  packed operand A
req_b  in  16*N_REQ  packed operand B
alu_op  out  3  to shared ALU
alu_a  out  16  to shared ALU
alu_b  out  16  to shared ALU
alu_out  in  16  from shared ALU
alu_sign, alu_zero, alu_parity, alu_overflow  in  1 each  ALU flags
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  index of the requester being answered
rsp_data  out  16  captured ALU result
rsp_flags  out  4  {overflow, parity, zero, sign}
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE and the RR pointer is 0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_flags=0, alu_op/a/b=0, busy=0.
- IDLE state:
  - Arbitrate combinationally, round-robin, starting at the RR pointer.
  - Winner w is the first index ≥ ptr (mod N_REQ) with req_valid set.
  - req_ready[w]=1 in the same cycle, so the handshake completes in this cycle.
  - At the clock edge, latch op/a/b of w and the id w, then set ptr=(w+1) mod N_REQ.
  - Go to EXEC. If no request is valid, stay in IDLE and leave ptr unchanged.
- EXEC state, exactly 1 cycle:
  - alu_op/a/b are driven from the latched registers. They are registered outputs, stable for the whole cycle.
  - At the edge, capture alu_out into rsp_data and the flags into rsp_flags, then go to RESP.
- Flag masking at capture:
  - sign is captured only when op[2:1]==2'b00, otherwise 0.
  - overflow is captured only when op==3'b000, otherwise 0.
  - zero and parity are always captured.
  - rsp_flags never carries X.
- RESP state:
  - rsp_valid=1, and rsp_id/data/flags are held stable until rsp_ready=1.
  - On the rsp_valid&&rsp_ready edge, go to IDLE.
  - No new grant happens in the RESP cycle.
- Latency and throughput:
  - Grant at cycle T, rsp_valid at T+2.
  - Minimum 3 cycles per operation; peak 1 op per 3 cycles.
- req_ready is 0 outside IDLE. Requesters hold valid and payload until their ready bit is seen.
- A requester that drops req_valid before being granted is simply skipped. This is not an error.
- rsp_ready held low: the block stalls indefinitely in RESP and all req_ready stay 0.
- Pointer wrap: after granting index N_REQ-1, ptr becomes 0.
- Reset mid-operation: the in-flight op is discarded without a response, and all outputs return to their reset values immediately.
- busy=1 in EXEC and RESP.

Optional Feature:
Macro ALU_SHARE_ARBITER_STATS_EN.
- When defined, add these ports:
  - stat_clr  in  1
  - stat_ops  out  32
  - stat_wait  out  32
- stat_ops counts completed responses (rsp_valid&&rsp_ready).
- stat_wait counts cycles in IDLE where any req_valid=1 but no grant occurred. This is structurally 0 and is retained as an invariant check; it also counts RESP cycles with any req_valid=1.
- Both counters saturate at 32'hFFFF_FFFF. They clear on reset or when stat_clr=1; stat_clr has priority over increment.
- When undefined, these ports and the counter logic are absent and behaviour is otherwise identical.

Test Plan:
- Single requester: req 0 sends ADD a=16'h7FFF, b=16'h0001 with rsp_ready=1 → grant at T, rsp_valid at T+2 with rsp_id=0, data=16'h8000, flags={ovf=1, par=0, zero=0, sign=1}.
- Flag masking: req 1 sends XOR a=16'h00FF, b=16'h00FF → data=0, flags={0,1,1,0}. Sign and overflow are 0 even though the ALU drives X.
- Round robin: all 4 requesters valid continuously → grant order 0,1,2,3,0,1 with one grant every 3 cycles. After a grant to 3, the next grant is 0.
- Backpressure: rsp_ready=0 for 5 cycles during RESP → rsp_id/data/flags stable, req_ready=0 throughout. Release → return to IDLE on the next edge.
- Reset mid-op: assert rst_n=0 in EXEC → rsp_valid never rises for that op. After release, ptr=0 and requester 0 wins first.
- STATS build: 3 completed ops, then stat_clr for one cycle → stat_ops reads 3, then 0. Preloaded at 32'hFFFF_FFFF, one more op leaves it at 32'hFFFF_FFFF.
